// File: rtl/dspsplit.sv
`default_nettype none
// ============================================================================
// Module   : dspsplit
// Purpose  : Sample-stream splitter. Registers every input sample towards the
//            filter and stores a raw copy in a show-ahead bypass FIFO. The
//            copy is held until the filter's output strobe consumes it, so the
//            downstream bypass switch sees processed and raw words together.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DW            sample width in bits
//   LGDEPTH       log2 of bypass FIFO depth (must cover filter samples in flight)
// Ports
//   i_clk         clock, rising edge
//   i_areset      asynchronous active-high reset
//   i_clear       synchronous flush of FIFO and sticky flags
//   i_ce          input sample strobe (push)
//   i_sample      input sample, valid with i_ce
//   o_filt_ce     registered strobe to the filter
//   o_filt_sample registered sample to the filter
//   i_filt_ce     filter output strobe (pop)
//   o_bypass      oldest unconsumed raw sample (registered show-ahead)
//   o_fill        FIFO occupancy, 0 .. 2^LGDEPTH
//   o_overflow    sticky: a push was dropped because the FIFO was full
//   o_underflow   sticky: a pop arrived while the FIFO was empty
// ============================================================================
module dspsplit #(
  parameter int DW      = 32,
  parameter int LGDEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_areset,
  input  logic               i_clear,
  input  logic               i_ce,
  input  logic [DW-1:0]      i_sample,
  output logic               o_filt_ce,
  output logic [DW-1:0]      o_filt_sample,
  input  logic               i_filt_ce,
  output logic [DW-1:0]      o_bypass,
  output logic [LGDEPTH:0]   o_fill,
  output logic               o_overflow,
  output logic               o_underflow
);

  localparam int                 DEPTH     = 1 << LGDEPTH;
  localparam logic [LGDEPTH:0]   C_FULL    = (LGDEPTH+1)'(DEPTH);
  localparam logic [LGDEPTH:0]   C_ONE     = (LGDEPTH+1)'(1);
  localparam logic [LGDEPTH-1:0] C_PTR_ONE = LGDEPTH'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DW-1:0]      mem_q [0:DEPTH-1];
  logic [LGDEPTH-1:0] wr_q, wr_d;
  logic [LGDEPTH-1:0] rd_q, rd_d;
  logic [LGDEPTH:0]   fill_q, fill_d;
  logic [DW-1:0]      bypass_q, bypass_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               filt_ce_q;
  logic [DW-1:0]      filt_sample_q;

  // --------------------------------------------------------------------------
  // Push / pop qualification
  // --------------------------------------------------------------------------
  logic               w_empty;
  logic               w_full;
  logic               w_push_ok;
  logic               w_pop_ok;
  logic               w_mem_we;
  logic [LGDEPTH-1:0] w_rd_next;

  assign w_empty   = (fill_q == '0);
  assign w_full    = (fill_q == C_FULL);
  // A push into a full FIFO is still accepted when a pop frees a slot on the
  // same edge; the write lands in the slot being vacated.
  assign w_push_ok = i_ce && (!w_full || i_filt_ce);
  // A pop on an empty FIFO is an underflow and never moves the read side.
  assign w_pop_ok  = i_filt_ce && !w_empty;
  assign w_mem_we  = w_push_ok && !i_clear;
  assign w_rd_next = rd_q + C_PTR_ONE;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wr_d     = wr_q;
    rd_d     = rd_q;
    fill_d   = fill_q;
    bypass_d = bypass_q;
    ovf_d    = ovf_q | (i_ce && w_full && !i_filt_ce);
    unf_d    = unf_q | (i_filt_ce && w_empty);

    if (w_push_ok) begin
      wr_d = wr_q + C_PTR_ONE;
    end
    if (w_pop_ok) begin
      rd_d = w_rd_next;
    end

    unique case ({w_push_ok, w_pop_ok})
      2'b10:   fill_d = fill_q + C_ONE;
      2'b01:   fill_d = fill_q - C_ONE;
      default: fill_d = fill_q;
    endcase

    // Show-ahead register: after a pop, present the entry behind the one just
    // consumed. With only one entry left that entry is the word being pushed
    // this very cycle (not yet in memory), so forward it from the input; with
    // no push the FIFO drains and the output holds its last value.
    if (w_pop_ok) begin
      if (fill_q == C_ONE) begin
        if (w_push_ok) begin
          bypass_d = i_sample;
        end
      end else begin
        bypass_d = mem_q[w_rd_next];
      end
    end else if (w_empty && w_push_ok) begin
      bypass_d = i_sample;
    end

    // Flush wins over any concurrent push or pop.
    if (i_clear) begin
      wr_d     = '0;
      rd_d     = '0;
      fill_d   = '0;
      bypass_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Storage array: contents are don't-care after reset, so no reset here.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      mem_q[wr_q] <= i_sample;
    end
  end

  // --------------------------------------------------------------------------
  // Control and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      wr_q          <= '0;
      rd_q          <= '0;
      fill_q        <= '0;
      bypass_q      <= '0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      filt_ce_q     <= 1'b0;
      filt_sample_q <= '0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      fill_q    <= fill_d;
      bypass_q  <= bypass_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      // Filter feed is never blocked by FIFO state or by a flush.
      filt_ce_q <= i_ce;
      if (i_ce) begin
        filt_sample_q <= i_sample;
      end
    end
  end

  assign o_filt_ce     = filt_ce_q;
  assign o_filt_sample = filt_sample_q;
  assign o_bypass      = bypass_q;
  assign o_fill        = fill_q;
  assign o_overflow    = ovf_q;
  assign o_underflow   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_dspsplit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dspsplit
// Purpose  : Directed self-checking bench for dspsplit with a 4-entry FIFO.
//            Inputs change on the falling edge; outputs are checked on the
//            falling edge after the rising edge that produced them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dspsplit;

  localparam int DW      = 32;
  localparam int LGDEPTH = 2;

  logic               clk = 1'b0;
  logic               areset = 1'b1;
  logic               clear = 1'b0;
  logic               ce = 1'b0;
  logic [DW-1:0]      sample = '0;
  logic               filt_ce_in = 1'b0;
  logic               filt_ce_out;
  logic [DW-1:0]      filt_sample;
  logic [DW-1:0]      bypass;
  logic [LGDEPTH:0]   fill;
  logic               overflow;
  logic               underflow;

  int n_pass  = 0;
  int n_total = 0;
  int peak    = 0;

  dspsplit #(.DW(DW), .LGDEPTH(LGDEPTH)) dut (
    .i_clk         (clk),
    .i_areset      (areset),
    .i_clear       (clear),
    .i_ce          (ce),
    .i_sample      (sample),
    .o_filt_ce     (filt_ce_out),
    .o_filt_sample (filt_sample),
    .i_filt_ce     (filt_ce_in),
    .o_bypass      (bypass),
    .o_fill        (fill),
    .o_overflow    (overflow),
    .o_underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance through one rising edge and stop on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic c, input logic [DW-1:0] s, input logic p, input logic clr);
    ce         = c;
    sample     = s;
    filt_ce_in = p;
    clear      = clr;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_filt_ce"},     {31'd0, filt_ce_out}, 0);
    check({tag, "_filt_sample"}, filt_sample,          0);
    check({tag, "_bypass"},      bypass,               0);
    check({tag, "_fill"},        {29'd0, fill},        0);
    check({tag, "_ovf"},         {31'd0, overflow},    0);
    check({tag, "_unf"},         {31'd0, underflow},   0);
  endtask

  initial begin
    // ---------------- reset and idle ----------------
    repeat (2) step();
    check_all_zero("rst");
    areset = 1'b0;
    repeat (3) step();
    check_all_zero("idle");

    // ---------------- latency-3 filter model ----------------
    for (int k = 0; k < 7; k++) begin
      drive(k < 3, DW'((k + 1) * 32'h11), (k >= 4), 1'b0);
      if (k >= 4) check($sformatf("lat3_pop%0d", k - 4), bypass, DW'((k - 3) * 32'h11));
      step();
      if (int'(fill) > peak) peak = int'(fill);
      if (k == 0) begin
        check("lat3_filt_ce",     {31'd0, filt_ce_out}, 1);
        check("lat3_filt_sample", filt_sample,          32'h11);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    check("lat3_peak",  peak,                 3);
    check("lat3_fill0", {29'd0, fill},        0);
    check("lat3_hold",  bypass,               32'h33);
    check("lat3_ovf",   {31'd0, overflow},    0);
    check("lat3_unf",   {31'd0, underflow},   0);

    // ---------------- full-rate streaming with wrap ----------------
    for (int k = 0; k < 12; k++) begin
      drive(k < 10, DW'(k), (k >= 2), 1'b0);
      if (k >= 2) check($sformatf("stream_pop%0d", k - 2), bypass, DW'(k - 2));
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    check("stream_fill0", {29'd0, fill},     0);
    check("stream_ovf",   {31'd0, overflow}, 0);
    check("stream_unf",   {31'd0, underflow},0);

    // ---------------- overflow ----------------
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, DW'(32'hA0 + k), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    check("ovf_fill4",      {29'd0, fill},     4);
    check("ovf_flag",       {31'd0, overflow}, 1);
    check("ovf_feed",       filt_sample,       32'hA4);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check($sformatf("ovf_pop%0d", k), bypass, DW'(32'hA0 + k));
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    check("ovf_drained", {29'd0, fill}, 0);
    check("ovf_lost",    bypass,        32'hA3);
    check("ovf_sticky",  {31'd0, overflow}, 1);

    // flush back to a clean empty state
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("clr1_ovf",    {31'd0, overflow}, 0);
    check("clr1_bypass", bypass,            0);

    // ---------------- underflow with simultaneous push ----------------
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("unf_flag",   {31'd0, underflow}, 1);
    check("unf_fill",   {29'd0, fill},      0);
    check("unf_bypass", bypass,             0);
    step();
    drive(1'b1, 32'h55, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("unfp_flag",   {31'd0, underflow}, 1);
    check("unfp_fill",   {29'd0, fill},      1);
    check("unfp_bypass", bypass,             32'h55);

    // ---------------- clear priority ----------------
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, DW'(32'h56 + k), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("pre_clr_fill", {29'd0, fill},      3);
    check("pre_clr_ovf",  {31'd0, overflow},  1);
    check("pre_clr_unf",  {31'd0, underflow}, 1);
    check("pre_clr_byp",  bypass,             32'h56);
    drive(1'b1, 32'h77, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("clr_fill",        {29'd0, fill},        0);
    check("clr_ovf",         {31'd0, overflow},    0);
    check("clr_unf",         {31'd0, underflow},   0);
    check("clr_bypass",      bypass,               0);
    check("clr_filt_sample", filt_sample,          32'h77);
    check("clr_filt_ce",     {31'd0, filt_ce_out}, 1);
    drive(1'b1, 32'h88, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("post_clr_bypass", bypass,        32'h88);
    check("post_clr_fill",   {29'd0, fill}, 1);

    // ---------------- asynchronous reset mid-operation ----------------
    drive(1'b1, 32'h99, 1'b0, 1'b0);
    #2 areset = 1'b1;
    #1 check_all_zero("arst");
    @(negedge clk);
    areset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    check_all_zero("arst_idle");
    drive(1'b1, 32'h99, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("arst_push_bypass", bypass,        32'h99);
    check("arst_push_fill",   {29'd0, fill}, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
